// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: PC, word-addressed instruction memory and registered RV32I decode
// with stall, branch redirect/flush and halt on system, illegal or misaligned conditions.
module instr_fetch_decode #(
  parameter int WIDTH = 32,
  parameter int IMEM_DEPTH = 256,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          branch_taken,
  input  logic [WIDTH-1:0]              branch_target,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  output logic [WIDTH-1:0]              pc,
  output logic [WIDTH-1:0]              dec_pc,
  output logic [31:0]                   instr,
  output logic                          valid,
  output logic [6:0]                    opcode,
  output logic [2:0]                    Funct3,
  output logic [6:0]                    Funct7,
  output logic [4:0]                    RS1,
  output logic [4:0]                    RS2,
  output logic [4:0]                    RD,
  output logic [4:0]                    Shamt,
  output logic [11:0]                   Imm_reg,
  output logic [19:0]                   Imm20,
  output logic                          write_en,
  output logic                          read_en,
  output logic                          store_en,
  output logic                          branch_op,
  output logic                          jump_op,
  output logic                          halted,
  output logic [1:0]                    halt_cause
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_SYS = 7'b1110011;
  typedef enum logic {RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [31:0] imem [IMEM_DEPTH];
  logic [WIDTH-1:0] pc_q, pc_d, dec_pc_q, dec_pc_d;
  logic [31:0] instr_q, instr_d, fetch;
  logic valid_q, valid_d;
  logic [4:0] ctl_q, ctl_d, f_ctl;
  logic [1:0] cause_q, cause_d;
  logic [6:0] f_op;
  logic f_sys, f_legal;
  assign fetch = imem[pc_q[AW+1:2]];
  assign f_op = fetch[6:0];
  assign f_sys = f_op == OP_SYS;
  assign f_legal = f_op inside {OP_R, OP_I, OP_L, OP_S, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  // {write_en, read_en, store_en, branch_op, jump_op}
  assign f_ctl = {f_op inside {OP_R, OP_I, OP_L, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC},
                  f_op == OP_L, f_op == OP_S, f_op == OP_B, f_op inside {OP_JAL, OP_JALR}};
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    dec_pc_d = dec_pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    ctl_d = ctl_q;
    cause_d = cause_q;
    if (state_q == RUN) begin
      if (branch_taken) begin
        valid_d = 1'b0;
        ctl_d = '0;
        state_d = |branch_target[1:0] ? HALT : RUN;
        cause_d = |branch_target[1:0] ? 2'd3 : cause_q;
        pc_d = |branch_target[1:0] ? pc_q : branch_target;
      end else if (!stall) begin
        pc_d = pc_q + WIDTH'(4);
        dec_pc_d = pc_q;
        instr_d = fetch;
        valid_d = f_legal;
        ctl_d = f_legal ? f_ctl : '0;
        state_d = f_legal ? RUN : HALT;
        cause_d = f_legal ? cause_q : f_sys ? 2'd1 : 2'd2;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      dec_pc_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      ctl_q <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      dec_pc_q <= dec_pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      ctl_q <= ctl_d;
      cause_q <= cause_d;
    end
  end
  // Programming is only allowed while fetch is not consuming the memory.
  always_ff @(posedge clk)
    if (prog_we && (rst || state_q == HALT)) imem[prog_addr] <= prog_data;
  assign pc = pc_q;
  assign dec_pc = dec_pc_q;
  assign instr = instr_q;
  assign valid = valid_q;
  assign opcode = instr_q[6:0];
  assign Funct3 = instr_q[14:12];
  assign Funct7 = instr_q[31:25];
  assign RS1 = instr_q[19:15];
  assign RS2 = instr_q[24:20];
  assign RD = instr_q[11:7];
  assign Shamt = instr_q[24:20];
  assign Imm20 = instr_q[31:12];
  assign Imm_reg = opcode inside {OP_I, OP_L, OP_JALR} ? instr_q[31:20] :
                   opcode == OP_S ? {instr_q[31:25], instr_q[11:7]} :
                   opcode == OP_B ? {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8]} : '0;
  assign {write_en, read_en, store_en, branch_op, jump_op} = ctl_q;
  assign halted = state_q == HALT;
  assign halt_cause = cause_q;
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: table vectors, directed corner sequences and random run
// compared against an instruction-level reference model.
module tb_instr_fetch_decode;
  logic clk = 0, rst = 1, stall = 0, branch_taken = 0, prog_we = 0;
  logic [31:0] branch_target = 0, prog_data = 0;
  logic [7:0] prog_addr = 0;
  logic [31:0] pc, dec_pc, instr;
  logic valid, write_en, read_en, store_en, branch_op, jump_op, halted;
  logic [6:0] opcode, Funct7;
  logic [2:0] Funct3;
  logic [4:0] RS1, RS2, RD, Shamt;
  logic [11:0] Imm_reg;
  logic [19:0] Imm20;
  logic [1:0] halt_cause;

  instr_fetch_decode dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .pc(pc), .dec_pc(dec_pc), .instr(instr), .valid(valid),
    .opcode(opcode), .Funct3(Funct3), .Funct7(Funct7), .RS1(RS1), .RS2(RS2), .RD(RD),
    .Shamt(Shamt), .Imm_reg(Imm_reg), .Imm20(Imm20), .write_en(write_en),
    .read_en(read_en), .store_en(store_en), .branch_op(branch_op), .jump_op(jump_op),
    .halted(halted), .halt_cause(halt_cause)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  logic [31:0] m_mem [256];
  logic [31:0] m_pc = 0, m_dec_pc = 0, m_instr = 0;
  bit m_valid = 0, m_halt = 0;
  logic [1:0] m_cause = 0;
  logic [4:0] m_ctl = 0;

  function automatic logic [4:0] strobes(input logic [6:0] op);
    case (op)
      7'h33, 7'h13, 7'h37, 7'h17: return 5'b10000;
      7'h03: return 5'b11000;
      7'h23: return 5'b00100;
      7'h63: return 5'b00010;
      7'h6F, 7'h67: return 5'b10001;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  endfunction

  function automatic logic [11:0] imm_of(input logic [31:0] w);
    case (w[6:0])
      7'h13, 7'h03, 7'h67: return w[31:20];
      7'h23: return {w[31:25], w[11:7]};
      7'h63: return {w[31], w[7], w[30:25], w[11:8]};
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [31:0] w = $urandom;
    int r = $urandom_range(0, 99);
    if (r < 4) w[6:0] = 7'h73;
    else if (r < 96) w[6:0] = ops[$urandom_range(0, 8)];
    return w;
  endfunction

  task automatic model_edge();
    logic [31:0] w;
    if (prog_we && (rst || m_halt)) m_mem[prog_addr] = prog_data;
    if (rst) begin
      m_pc = 0; m_dec_pc = 0; m_instr = 0; m_valid = 0; m_halt = 0; m_cause = 0; m_ctl = 0;
    end else if (!m_halt) begin
      if (branch_taken) begin
        m_valid = 0; m_ctl = 0;
        if (branch_target % 4 != 0) begin m_halt = 1; m_cause = 3; end
        else m_pc = branch_target;
      end else if (!stall) begin
        w = m_mem[(m_pc / 4) % 256];
        m_instr = w; m_dec_pc = m_pc; m_pc = m_pc + 4;
        if (legal(w[6:0])) begin m_valid = 1; m_ctl = strobes(w[6:0]); end
        else begin
          m_valid = 0; m_ctl = 0; m_halt = 1;
          m_cause = (w[6:0] == 7'h73) ? 2'd1 : 2'd2;
        end
      end
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("dec_pc", dec_pc, m_dec_pc);
    check("instr", instr, m_instr);
    check("valid", valid, m_valid);
    check("halted", halted, m_halt);
    check("halt_cause", halt_cause, m_cause);
    check("strobes", {write_en, read_en, store_en, branch_op, jump_op}, m_ctl);
    check("imm_reg", Imm_reg, imm_of(m_instr));
    check("imm20", Imm20, m_instr[31:12]);
    check("fields", {opcode, Funct3, Funct7, RS1, RS2, RD, Shamt},
          {m_instr[6:0], m_instr[14:12], m_instr[31:25], m_instr[19:15],
           m_instr[24:20], m_instr[11:7], m_instr[24:20]});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic load(input logic [7:0] idx, input logic [31:0] word);
    rst = 1; prog_we = 1; prog_addr = idx; prog_data = word;
    step();
    prog_we = 0;
  endtask

  typedef struct {
    logic [31:0] word;
    bit v;
    logic [4:0] ctl;
    logic [11:0] imm;
    logic [1:0] cause;
  } vec_t;

  vec_t tv [10];

  initial begin
    tv[0] = '{32'h00500093, 1, 5'b10000, 12'h005, 2'd0};
    tv[1] = '{32'h0020A423, 1, 5'b00100, 12'h008, 2'd0};
    tv[2] = '{32'h00000073, 0, 5'b00000, 12'h000, 2'd1};
    tv[3] = '{32'hFFFFFFFF, 0, 5'b00000, 12'h000, 2'd2};
    tv[4] = '{32'hFFC12283, 1, 5'b11000, 12'hFFC, 2'd0};
    tv[5] = '{32'h00208463, 1, 5'b00010, 12'h004, 2'd0};
    tv[6] = '{32'h000000EF, 1, 5'b10001, 12'h000, 2'd0};
    tv[7] = '{32'h123451B7, 1, 5'b10000, 12'h000, 2'd0};
    tv[8] = '{32'h002081B3, 1, 5'b10000, 12'h000, 2'd0};
    tv[9] = '{32'h00008067, 1, 5'b10001, 12'h000, 2'd0};

    step();
    check("reset_valid", valid, 0);
    check("reset_pc", pc, 0);

    for (int i = 0; i < 10; i++) begin
      load(0, tv[i].word);
      rst = 0;
      step();
      check("tv_valid", valid, tv[i].v);
      check("tv_strobes", {write_en, read_en, store_en, branch_op, jump_op}, tv[i].ctl);
      check("tv_imm", Imm_reg, tv[i].imm);
      check("tv_cause", halt_cause, tv[i].cause);
    end

    // straight-line run, stall, redirect under stall, misaligned halt
    for (int i = 0; i < 16; i++) load(8'(i), (i == 0) ? 32'h00500093 : (32'h00000093 | (i << 20)));
    rst = 0;
    step();
    check("first_valid", valid, 1);
    check("first_op", opcode, 7'h13);
    check("first_rd", RD, 1);
    check("first_imm", Imm_reg, 12'h005);
    check("first_we", write_en, 1);
    check("first_pc", pc, 4);
    check("first_dec_pc", dec_pc, 0);
    step();
    check("seq_dec_pc4", dec_pc, 4);
    stall = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("stall_dec_pc", dec_pc, 4);
      check("stall_pc", pc, 8);
      check("stall_imm", Imm_reg, 12'h001);
    end
    stall = 0;
    step();
    check("seq_dec_pc8", dec_pc, 8);
    step();
    check("seq_dec_pc12", dec_pc, 12);
    check("seq_pc16", pc, 16);
    stall = 1; branch_taken = 1; branch_target = 32'h20;
    step();
    check("br_pc", pc, 32'h20);
    check("br_flush", valid, 0);
    check("br_flush_we", write_en, 0);
    stall = 0; branch_taken = 0;
    step();
    check("br_dec_pc", dec_pc, 32'h20);
    check("br_valid", valid, 1);
    check("br_pc_next", pc, 32'h24);
    branch_taken = 1; branch_target = 32'h22;
    step();
    check("mis_halted", halted, 1);
    check("mis_cause", halt_cause, 3);
    check("mis_pc", pc, 32'h24);
    branch_taken = 0;
    prog_we = 1; prog_addr = 1; prog_data = 32'h00000073;
    step();
    prog_we = 0; rst = 1;
    step();
    check("restart_pc", pc, 0);
    check("restart_halted", halted, 0);
    rst = 0;
    step();
    check("restart_dec_pc", dec_pc, 0);
    check("restart_valid", valid, 1);
    step();
    check("ecall_halted", halted, 1);
    check("ecall_cause", halt_cause, 1);
    check("ecall_we", write_en, 0);
    check("ecall_valid", valid, 0);
    branch_taken = 1; branch_target = 32'h40; stall = 1;
    step();
    check("halt_pc_frozen", pc, 8);
    check("halt_still", halted, 1);
    branch_taken = 0; stall = 0;

    // reset dominance, write gating in RUN, pc wrap
    load(0, 32'h0020A423);
    load(1, 32'h00500093);
    load(255, 32'h00500093);
    branch_taken = 1; branch_target = 32'h22;
    step();
    check("rst_dom_halted", halted, 0);
    check("rst_dom_pc", pc, 0);
    branch_taken = 0; rst = 0;
    prog_we = 1; prog_addr = 1; prog_data = 32'hFFFFFFFF;
    step();
    check("sw_store", store_en, 1);
    check("sw_we", write_en, 0);
    check("sw_imm", Imm_reg, 12'h008);
    prog_we = 0;
    step();
    check("run_write_ignored", instr, 32'h00500093);
    check("run_write_valid", valid, 1);
    branch_taken = 1; branch_target = 32'hFFFFFFFC;
    step();
    check("wrap_target", pc, 32'hFFFFFFFC);
    branch_taken = 0;
    step();
    check("wrap_pc", pc, 0);
    check("wrap_dec_pc", dec_pc, 32'hFFFFFFFC);

    // randomized run against the model
    rst = 1;
    for (int i = 0; i < 256; i++) begin
      prog_we = 1; prog_addr = 8'(i); prog_data = rand_word();
      step();
    end
    prog_we = 0; rst = 0;
    for (int c = 0; c < 1500; c++) begin
      stall = ($urandom % 5) == 0;
      branch_taken = ($urandom % 10) == 0;
      branch_target = ($urandom % 40 == 0) ? ($urandom | 32'h1) :
                      ($urandom % 8 == 0) ? ($urandom & ~32'h3) :
                      32'($urandom_range(0, 1023)) & ~32'h3;
      prog_we = ($urandom % 4) == 0;
      prog_addr = 8'($urandom);
      prog_data = rand_word();
      rst = (m_halt && ($urandom % 6 == 0)) || ($urandom % 200 == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
